leer_rtc: RTL

LEER_RTC -- requirements
Module: leer_rtc

---
 rtl/leer_rtc.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/leer_rtc.sv
// leer_rtc: burst reader for six consecutive RTC time registers.
// Address/read strobes with idle gaps; outputs update atomically.
module leer_rtc #(
    parameter int          STROBE    = 8,
    parameter int          GAP       = 2,
    parameter logic [7:0]  BASE_ADDR = 8'h21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GAP1, S_READ, S_GAP2, S_DONE
    } state_t;

    localparam logic [7:0] STB_LAST = 8'(STROBE - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [5:0][7:0] shadow_q, shadow_d;
    logic [5:0][7:0] time_q, time_d;
    logic            last_stb, last_gap;

    assign last_stb = (cnt_q == STB_LAST);
    assign last_gap = (cnt_q == GAP_LAST);

    // Next-state: phase sequencing, capture on last READ cycle,
    // all six outputs load together when entering DONE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        time_d   = time_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADDR;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                end
            end
            S_ADDR: begin
                if (last_stb) begin
                    state_d = S_GAP1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP1: begin
                if (last_gap) begin
                    state_d = S_READ;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_READ: begin
                if (last_stb) begin
                    shadow_d[idx_q] = data_in;
                    state_d         = S_GAP2;
                    cnt_d           = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP2: begin
                if (last_gap) begin
                    cnt_d = 8'd0;
                    if (idx_q == 3'd5) begin
                        state_d = S_DONE;
                        time_d  = shadow_q;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_ADDR;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, shadow and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            cnt_q    <= 8'd0;
            shadow_q <= '0;
            time_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            time_q   <= time_d;
        end
    end

    // Bus and status decode; idle levels unless strobing.
    always_comb begin
        ad_out = 8'h00;
        ad_oe  = 1'b0;
        ad_sel = 1'b0;
        cs_n   = 1'b1;
        wr_n   = 1'b1;
        rd_n   = 1'b1;
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        unique case (state_q)
            S_ADDR: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = BASE_ADDR + {5'd0, idx_q};
            end
            S_READ: begin
                cs_n   = 1'b0;
                rd_n   = 1'b0;
                ad_sel = 1'b1;
            end
            default: begin
                ad_out = 8'h00;
            end
        endcase
    end

    assign seg  = time_q[0];
    assign min  = time_q[1];
    assign hora = time_q[2];
    assign dia  = time_q[3];
    assign mes  = time_q[4];
    assign anio = time_q[5];

endmodule
